// File: rtl/grn_pkg.sv
// Shared definitions for the Boolean gene-regulatory-network node.
package grn_pkg;

  // Per-channel perturbation mode applied at each update event.
  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,  // follow the truth table
    MODE_KO     = 2'b01,  // knockout: force 0
    MODE_OE     = 2'b10,  // overexpression: force 1
    MODE_HOLD   = 2'b11   // keep current state, phase still advances
  } grn_mode_e;

  // Next gene state for one update event under the given mode.
  function automatic logic grn_next_state(input grn_mode_e mode,
                                          input logic      lut_bit,
                                          input logic      cur);
    logic nxt;
    case (mode)
      MODE_NORMAL: nxt = lut_bit;
      MODE_KO:     nxt = 1'b0;
      MODE_OE:     nxt = 1'b1;
      MODE_HOLD:   nxt = cur;
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/grn_node_ch.sv
// One simulation channel: strobe divider, next-state select, saturating
// flip counter and stability flag. The truth-table bit is supplied by the top.
module grn_node_ch
  import grn_pkg::*;
#(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_nos,
  input  logic             init_state,
  input  logic             start,
  input  logic [DIV_W-1:0] ch_div,
  input  logic [1:0]       ch_mode,
  input  logic             lut_bit,
  output logic             s,
  output logic [CNT_W-1:0] flip_cnt,
  output logic             stable
);

  localparam logic [DIV_W-1:0] PH_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] PH_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             s_r;
  logic             stable_r;
  logic [DIV_W-1:0] phase_r;
  logic [CNT_W-1:0] cnt_r;
  logic             upd_s;
  logic             nxt_s;

  // Decide whether this strobe is an update event and what the new state is.
  always_comb begin
    upd_s = 1'b0;
    nxt_s = grn_next_state(grn_mode_e'(ch_mode), lut_bit, s_r);
    if (start && (phase_r == PH_ZERO)) begin
      upd_s = 1'b1;
    end else begin
      upd_s = 1'b0;
    end
  end

  // Channel state: reset, reload from init, or advance on a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r      <= 1'b0;
      stable_r <= 1'b0;
      phase_r  <= PH_ZERO;
      cnt_r    <= CNT_ZERO;
    end else if (reset_nos) begin
      s_r      <= init_state;
      stable_r <= 1'b0;
      phase_r  <= PH_ZERO;
      cnt_r    <= CNT_ZERO;
    end else if (upd_s) begin
      // Divider reload happens only here, so a changed ch_div never
      // disturbs a countdown already in progress.
      phase_r <= ch_div;
      s_r     <= nxt_s;
      if (nxt_s != s_r) begin
        stable_r <= 1'b0;
        cnt_r    <= (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
      end else begin
        stable_r <= 1'b1;
      end
    end else if (start) begin
      phase_r <= phase_r - PH_ONE;
    end
  end

  assign s        = s_r;
  assign flip_cnt = cnt_r;
  assign stable   = stable_r;

endmodule

// File: rtl/grn_node_lut.sv
// Boolean GRN node: runtime-loadable truth table shared by NUM_CH
// independent simulation channels.
module grn_node_lut
  import grn_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reset_nos,
  input  logic [NUM_CH-1:0]       init_state,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  input  logic [NUM_CH*2-1:0]     ch_mode,
  input  logic [NUM_CH*NUM_IN-1:0] in_state,
  input  logic                    cfg_we,
  input  logic [NUM_IN-1:0]       cfg_addr,
  input  logic                    cfg_data,
  output logic [NUM_CH-1:0]       s,
  output logic [NUM_CH*CNT_W-1:0] flip_cnt,
  output logic [NUM_CH-1:0]       stable
);

  localparam int LUT_N = 1 << NUM_IN;

  logic [LUT_N-1:0]  lut_r;
  logic [NUM_CH-1:0] lut_bit_s;

  // Truth-table storage; a same-cycle update still reads the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_r <= {LUT_N{1'b0}};
    end else if (cfg_we) begin
      lut_r[cfg_addr] <= cfg_data;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign lut_bit_s[c] = lut_r[in_state[c*NUM_IN +: NUM_IN]];

    grn_node_ch #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .reset_nos  (reset_nos),
      .init_state (init_state[c]),
      .start      (start[c]),
      .ch_div     (ch_div[c*DIV_W +: DIV_W]),
      .ch_mode    (ch_mode[c*2 +: 2]),
      .lut_bit    (lut_bit_s[c]),
      .s          (s[c]),
      .flip_cnt   (flip_cnt[c*CNT_W +: CNT_W]),
      .stable     (stable[c])
    );
  end

endmodule

// File: tb/tb_grn_node_lut.sv
// Self-checking bench for grn_node_lut (NUM_IN=4, NUM_CH=2, DIV_W=4, CNT_W=2).
module tb_grn_node_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset_nos;
  logic [1:0] init_state;
  logic [1:0] start;
  logic [7:0] ch_div;
  logic [3:0] ch_mode;
  logic [7:0] in_state;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic       cfg_data;
  logic [1:0] s;
  logic [3:0] flip_cnt;
  logic [1:0] stable;

  typedef struct {
    logic       r;
    logic       rn;
    logic [1:0] init;
    logic [1:0] st;
    logic [7:0] div;
    logic [3:0] md;
    logic [7:0] ins;
    logic       we;
    logic [3:0] addr;
    logic       dat;
    logic [1:0] es;
    logic [3:0] ec;
    logic [1:0] est;
  } vec_t;

  typedef struct {
    logic [1:0] es;
    logic [3:0] ec;
    logic [1:0] est;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[12];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   vec_id = 0;

  grn_node_lut #(.NUM_IN(4), .NUM_CH(2), .DIV_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start(start), .ch_div(ch_div), .ch_mode(ch_mode), .in_state(in_state),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s(s), .flip_cnt(flip_cnt), .stable(stable)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic rn, input logic [1:0] init,
                              input logic [1:0] st, input logic [7:0] div,
                              input logic [3:0] md, input logic [7:0] ins,
                              input logic we, input logic [3:0] addr, input logic dat,
                              input logic [1:0] es, input logic [3:0] ec,
                              input logic [1:0] est);
    vec_t v;
    v.r = r; v.rn = rn; v.init = init; v.st = st; v.div = div; v.md = md;
    v.ins = ins; v.we = we; v.addr = addr; v.dat = dat;
    v.es = es; v.ec = ec; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [3:0] act,
                     input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s vec=%0d actual=%b required=%b", name, id, act, exp);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic cycle(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = v.r; reset_nos = v.rn; init_state = v.init; start = v.st;
    ch_div = v.div; ch_mode = v.md; in_state = v.ins;
    cfg_we = v.we; cfg_addr = v.addr; cfg_data = v.dat;
    e.es = v.es; e.ec = v.ec; e.est = v.est; e.id = vec_id;
    sb_q.push_back(e);
    vec_id++;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      got = sb_q.pop_front();
      chk("s", got.id, {2'b00, s}, {2'b00, got.es});
      chk("flip_cnt", got.id, flip_cnt, got.ec);
      chk("stable", got.id, {2'b00, stable}, {2'b00, got.est});
    end
  endtask

  initial begin
    rst = 1'b1; reset_nos = 1'b0; init_state = 2'b00; start = 2'b00;
    ch_div = 8'h00; ch_mode = 4'h0; in_state = 8'h00;
    cfg_we = 1'b0; cfg_addr = 4'h0; cfg_data = 1'b0;

    // AND4 table: only entry 15 is 1; ch0 sees 1111, ch1 sees 0111.
    tbl[0]  = mk(1'b1,1'b0,2'b00,2'b00,8'h00,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b00,4'b0000,2'b00);
    tbl[1]  = mk(1'b0,1'b0,2'b00,2'b00,8'h00,4'h0,8'h00,1'b1,4'd15,1'b1,2'b00,4'b0000,2'b00);
    tbl[2]  = mk(1'b0,1'b1,2'b00,2'b00,8'h00,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b00,4'b0000,2'b00);
    tbl[3]  = mk(1'b0,1'b0,2'b00,2'b11,8'h00,4'h0,8'h7F,1'b0,4'd0, 1'b0,2'b01,4'b0001,2'b10);
    tbl[4]  = mk(1'b0,1'b0,2'b00,2'b11,8'h00,4'h0,8'h7F,1'b0,4'd0, 1'b0,2'b01,4'b0001,2'b11);
    // Divider: ch_div0=1, ch_div1=2, table all ones, init 0, six strobes.
    tbl[5]  = mk(1'b0,1'b1,2'b00,2'b00,8'h21,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b00,4'b0000,2'b00);
    tbl[6]  = mk(1'b0,1'b0,2'b00,2'b11,8'h21,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b11,4'b0101,2'b00);
    tbl[7]  = mk(1'b0,1'b0,2'b00,2'b11,8'h21,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b11,4'b0101,2'b00);
    tbl[8]  = mk(1'b0,1'b0,2'b00,2'b11,8'h21,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b11,4'b0101,2'b01);
    tbl[9]  = mk(1'b0,1'b0,2'b00,2'b11,8'h21,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b11,4'b0101,2'b11);
    tbl[10] = mk(1'b0,1'b0,2'b00,2'b11,8'h21,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b11,4'b0101,2'b11);
    tbl[11] = mk(1'b0,1'b0,2'b00,2'b11,8'h21,4'h0,8'h00,1'b0,4'd0, 1'b0,2'b11,4'b0101,2'b11);

    for (int i = 0; i < 5; i++) cycle(tbl[i]);
    // Fill entries 0..14 with 1; outputs must not move.
    for (int i = 0; i < 15; i++) begin
      logic [3:0] a;
      a = i[3:0];
      cycle(mk(1'b0,1'b0,2'b00,2'b00,8'h21,4'h0,8'h00,1'b1,a,1'b1,2'b01,4'b0001,2'b11));
    end
    for (int i = 5; i < 12; i++) cycle(tbl[i]);

    // Modes: s=11; ch0 knockout, then overexpress, then hold against a 0 entry.
    cycle(mk(1'b0,1'b1,2'b11,2'b00,8'h00,4'h0,8'h00,1'b0,4'd0,1'b0,2'b11,4'b0000,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h00,4'h1,8'h00,1'b0,4'd0,1'b0,2'b10,4'b0001,2'b10));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h00,4'h2,8'h00,1'b0,4'd0,1'b0,2'b11,4'b0010,2'b10));
    cycle(mk(1'b0,1'b0,2'b00,2'b00,8'h00,4'h3,8'h00,1'b1,4'd0,1'b0,2'b11,4'b0010,2'b10));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h00,4'h3,8'h00,1'b0,4'd0,1'b0,2'b01,4'b0110,2'b01));

    // Write collision: LUT[5]=0, then write 1 in the same cycle as a strobe.
    cycle(mk(1'b0,1'b0,2'b00,2'b00,8'h00,4'h0,8'h05,1'b1,4'd5,1'b0,2'b01,4'b0110,2'b01));
    cycle(mk(1'b0,1'b1,2'b00,2'b00,8'h00,4'h0,8'h05,1'b0,4'd0,1'b0,2'b00,4'b0000,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h0,8'h05,1'b1,4'd5,1'b1,2'b00,4'b0000,2'b01));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h0,8'h05,1'b0,4'd0,1'b0,2'b01,4'b0001,2'b00));

    // Saturation of the 2-bit counter via alternating overexpress/knockout.
    cycle(mk(1'b0,1'b1,2'b00,2'b00,8'h00,4'h0,8'h00,1'b0,4'd0,1'b0,2'b00,4'b0000,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h2,8'h00,1'b0,4'd0,1'b0,2'b01,4'b0001,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h1,8'h00,1'b0,4'd0,1'b0,2'b00,4'b0010,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h2,8'h00,1'b0,4'd0,1'b0,2'b01,4'b0011,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h1,8'h00,1'b0,4'd0,1'b0,2'b00,4'b0011,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h2,8'h00,1'b0,4'd0,1'b0,2'b01,4'b0011,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b01,8'h00,4'h1,8'h00,1'b0,4'd0,1'b0,2'b00,4'b0011,2'b00));

    // reset_nos mid-countdown with ch_div=3; start during reset_nos is ignored.
    cycle(mk(1'b0,1'b1,2'b00,2'b00,8'h33,4'h0,8'h05,1'b0,4'd0,1'b0,2'b00,4'b0000,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h33,4'h0,8'h05,1'b0,4'd0,1'b0,2'b01,4'b0001,2'b10));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h33,4'h0,8'h05,1'b0,4'd0,1'b0,2'b01,4'b0001,2'b10));
    cycle(mk(1'b0,1'b1,2'b11,2'b11,8'h33,4'h0,8'h05,1'b0,4'd0,1'b0,2'b11,4'b0000,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h33,4'h0,8'h05,1'b0,4'd0,1'b0,2'b01,4'b0100,2'b01));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h33,4'h0,8'h05,1'b0,4'd0,1'b0,2'b01,4'b0100,2'b01));

    // rst mid-run clears outputs and the table; a write during rst is dropped.
    cycle(mk(1'b1,1'b0,2'b00,2'b11,8'h33,4'h0,8'h05,1'b1,4'd0,1'b1,2'b00,4'b0000,2'b00));
    cycle(mk(1'b0,1'b1,2'b11,2'b00,8'h00,4'h0,8'h05,1'b0,4'd0,1'b0,2'b11,4'b0000,2'b00));
    cycle(mk(1'b0,1'b0,2'b00,2'b11,8'h00,4'h0,8'h05,1'b0,4'd0,1'b0,2'b00,4'b0101,2'b00));

    if (sb_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
